tx_msg_sequencer: RTL and testbench

TX_MSG_SEQUENCER -- requirements
Module: tx_msg_sequencer

---
 rtl/tx_msg_sequencer_if.sv | 31 +++
 rtl/tx_msg_sequencer.sv | 149 ++++++++++++++
 tb/tb_tx_msg_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_msg_sequencer_if.sv
// Host/transmitter-side signal bundle for tx_msg_sequencer: buffer write port,
// pass control, transmitter handshake and status.
interface tx_msg_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int AW = $clog2(DEPTH);

   logic              WrEn;
   logic [AW-1:0]     WrAddr;
   logic [DATA_W-1:0] WrData;
   logic [AW:0]       MsgLen;
   logic              Start;
   logic              Repeat;
   logic              TxEmpty;
   logic [DATA_W-1:0] TxData;
   logic              XMitGo;
   logic              Busy;
   logic              Done;
   logic [2:0]        OutState;

   modport master (
      output WrEn, WrAddr, WrData, MsgLen, Start, Repeat, TxEmpty,
      input  TxData, XMitGo, Busy, Done, OutState
   );

   modport slave (
      input  WrEn, WrAddr, WrData, MsgLen, Start, Repeat, TxEmpty,
      output TxData, XMitGo, Busy, Done, OutState
   );
endinterface

// File: rtl/tx_msg_sequencer.sv
// Message buffer sequencer: plays MsgLen buffered symbols to a transmitter one handshake
// at a time, optionally repeating after an idle gap. Macro TX_MSG_SEQUENCER_CRLF_EN appends CR LF.
module tx_msg_sequencer #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 16,
   parameter int GAP_CYCLES = 50_000_000
) (
   input  logic              clk,
   input  logic              rst,
   tx_msg_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   // GAP occupies GAP_CYCLES cycles, with a floor of one cycle when GAP_CYCLES is 0
   localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
   localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      FETCH      = 3'd1,
      SEND       = 3'd2,
      WAIT_BUSY  = 3'd3,
      WAIT_EMPTY = 3'd4,
      GAP        = 3'd5
   } state_t;

   state_t            state;
   logic [AW-1:0]     idx;
   logic [AW-1:0]     lastIdx;
   logic [GW-1:0]     gapCnt;
   logic [DATA_W-1:0] rdData;
   logic [DATA_W-1:0] txData;
   logic              xmitGo;
   logic              done;
   logic [AW:0]       lenClamp;
   logic [DATA_W-1:0] sendData;
   logic [DATA_W-1:0] mem [DEPTH];

   assign bus.TxData   = txData;
   assign bus.XMitGo   = xmitGo;
   assign bus.Done     = done;
   assign bus.Busy     = (state != IDLE);
   assign bus.OutState = state;

   always_comb begin
      lenClamp = (bus.MsgLen > LEN_MAX) ? LEN_MAX : bus.MsgLen;
   end

   // Buffer is only writable while idle; no reset so contents survive rst
   always_ff @(posedge clk) begin
      if (bus.WrEn && state == IDLE && {1'b0, bus.WrAddr} < LEN_MAX)
         mem[bus.WrAddr] <= bus.WrData;
   end

`ifdef TX_MSG_SEQUENCER_CRLF_EN
   // tail: 0 = buffer symbols, 1 = CR, 2 = LF
   logic [1:0] tail;

   always_comb begin
      case (tail)
         2'd0:    sendData = rdData;
         2'd1:    sendData = DATA_W'(8'h0D);
         default: sendData = DATA_W'(8'h0A);
      endcase
   end
`else
   assign sendData = rdData;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         idx     <= '0;
         lastIdx <= '0;
         gapCnt  <= '0;
         rdData  <= '0;
         txData  <= '0;
         xmitGo  <= 1'b0;
         done    <= 1'b0;
`ifdef TX_MSG_SEQUENCER_CRLF_EN
         tail    <= 2'd0;
`endif
      end else begin
         xmitGo <= 1'b0;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.Start && bus.MsgLen != '0) begin
                  lastIdx <= AW'(lenClamp - (AW+1)'(1));
                  idx     <= '0;
                  state   <= FETCH;
               end
            end
            FETCH: begin
               rdData <= mem[idx];
               state  <= SEND;
            end
            SEND: begin
               if (bus.TxEmpty) begin
                  txData <= sendData;
                  xmitGo <= 1'b1;
                  state  <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (!bus.TxEmpty)
                  state <= WAIT_EMPTY;
            end
            WAIT_EMPTY: begin
               if (bus.TxEmpty) begin
`ifdef TX_MSG_SEQUENCER_CRLF_EN
                  if (tail == 2'd0 && idx != lastIdx) begin
                     idx   <= idx + AW'(1);
                     state <= FETCH;
                  end else if (tail != 2'd2) begin
                     tail  <= tail + 2'd1;
                     state <= FETCH;
                  end else begin
                     tail   <= 2'd0;
                     done   <= 1'b1;
                     gapCnt <= '0;
                     state  <= GAP;
                  end
`else
                  if (idx != lastIdx) begin
                     idx   <= idx + AW'(1);
                     state <= FETCH;
                  end else begin
                     done   <= 1'b1;
                     gapCnt <= '0;
                     state  <= GAP;
                  end
`endif
               end
            end
            GAP: begin
               if (gapCnt == GAP_LAST) begin
                  gapCnt <= '0;
                  idx    <= '0;
                  state  <= bus.Repeat ? FETCH : IDLE;
               end else begin
                  gapCnt <= gapCnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tx_msg_sequencer.sv
// Self-checking bench for tx_msg_sequencer: transmitter model, byte/timing scoreboard,
// directed and randomized passes.
module tb_tx_msg_sequencer;
   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam int G = 20;

   logic clk;
   logic rst;
   tx_msg_sequencer_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

   tx_msg_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .GAP_CYCLES(G)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [7:0] refMem [DEPTH];
   logic [7:0] capQ[$];
   int xmitCycQ[$];
   int doneCycQ[$];
   int doneCnt = 0;
   int consecErr = 0;
   int busyLeft = 0;
   bit prevGo = 0;
   bit hold = 0;
   bit randBusy = 0;
   int startCyc;

   // Transmitter model: goes busy on each XMitGo, logs symbols, Done and timing
   always @(negedge clk) begin
      if (!rst) begin
         busyLeft = 0;
         prevGo = 0;
      end else begin
         if (bus.XMitGo === 1'b1) begin
            capQ.push_back(bus.TxData);
            xmitCycQ.push_back(cyc);
            if (prevGo) consecErr++;
            busyLeft = randBusy ? int'($urandom_range(1, 12)) : 10;
         end else if (busyLeft > 0) begin
            busyLeft--;
         end
         if (bus.Done === 1'b1) begin
            doneCnt++;
            doneCycQ.push_back(cyc);
         end
         prevGo = (bus.XMitGo === 1'b1);
      end
      bus.TxEmpty = (busyLeft == 0) && !hold;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic writeAll();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         bus.WrEn = 1'b1;
         bus.WrAddr = 4'(i);
         bus.WrData = refMem[i];
      end
      @(negedge clk);
      bus.WrEn = 1'b0;
   endtask

   task automatic startPass(input int len);
      @(negedge clk);
      bus.MsgLen = 5'(len);
      bus.Start = 1'b1;
      @(negedge clk);
      startCyc = cyc;
      bus.Start = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input int maxCyc);
      int n = 0;
      while (bus.Busy === 1'b1 && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, {31'd0, bus.Busy}, 32'd0);
   endtask

   function automatic int symsPerPass(input int len);
      int n = (len > DEPTH) ? DEPTH : len;
`ifdef TX_MSG_SEQUENCER_CRLF_EN
      n += 2;
`endif
      return n;
   endfunction

   // Expected stream: first min(len,DEPTH) buffer bytes (+ CR LF), repeated per pass
   task automatic checkPass(input string tag, input int len, input int passes);
      logic [7:0] expQ[$];
      int n = (len > DEPTH) ? DEPTH : len;
      logic [31:0] obs;
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < n; i++) expQ.push_back(refMem[i]);
`ifdef TX_MSG_SEQUENCER_CRLF_EN
         expQ.push_back(8'h0D);
         expQ.push_back(8'h0A);
`endif
      end
      chk({tag, "_count"}, capQ.size(), expQ.size());
      chk({tag, "_done"}, doneCnt, passes);
      for (int i = 0; i < expQ.size(); i++) begin
         obs = (i < capQ.size()) ? {24'd0, capQ[i]} : 32'hdead_beef;
         chk($sformatf("%s_sym%0d", tag, i), obs, {24'd0, expQ[i]});
      end
      capQ.delete();
      xmitCycQ.delete();
      doneCycQ.delete();
      doneCnt = 0;
   endtask

   initial begin
      int len;
      int n;
      int anyBusy;
      rst = 1'b0;
      bus.WrEn = 1'b0;
      bus.WrAddr = '0;
      bus.WrData = '0;
      bus.MsgLen = '0;
      bus.Start = 1'b0;
      bus.Repeat = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {bus.Busy, bus.OutState, bus.XMitGo, bus.Done, bus.TxData}, 32'd0);
      rst = 1'b1;

      // "Hello", fixed 10-cycle transmitter
      for (int i = 0; i < DEPTH; i++) refMem[i] = 8'($urandom);
      refMem[0] = 8'h48; refMem[1] = 8'h65; refMem[2] = 8'h6C; refMem[3] = 8'h6C; refMem[4] = 8'h6F;
      writeAll();
      startPass(5);
      chk("start_busy", {31'd0, bus.Busy}, 32'd1);
      waitIdle("hello", 400);
      chk("latency", (xmitCycQ.size() > 0) ? xmitCycQ[0] : -1, startCyc + 2);
      checkPass("hello", 5, 1);

      // Randomized messages and transmitter busy times
      randBusy = 1;
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < DEPTH; i++) refMem[i] = 8'($urandom);
         writeAll();
         len = $urandom_range(1, DEPTH);
         startPass(len);
         waitIdle($sformatf("rnd%0d", t), 1000);
         checkPass($sformatf("rnd%0d", t), len, 1);
      end
      randBusy = 0;

      // Oversized length clamps to DEPTH
      startPass(DEPTH + 1);
      waitIdle("clamp", 1000);
      checkPass("clamp", DEPTH + 1, 1);

      // Zero length is ignored
      startPass(0);
      anyBusy = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.Busy === 1'b1) anyBusy = 1;
      end
      chk("len0_busy", anyBusy, 0);
      chk("len0_xmit", capQ.size(), 0);

      // Repeat: gap timing, then drop Repeat
      bus.Repeat = 1'b1;
      startPass(3);
      n = 0;
      while (doneCnt < 2 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("rpt_two_done", {31'd0, doneCnt >= 2}, 32'd1);
      // GAP holds G cycles after Done, then FETCH and SEND
      chk("rpt_gap", (xmitCycQ.size() > symsPerPass(3)) ? xmitCycQ[symsPerPass(3)] : -1,
          (doneCycQ.size() > 0) ? doneCycQ[0] + G + 2 : -2);
      bus.Repeat = 1'b0;
      waitIdle("rpt", 1000);
      checkPass("rpt", 3, doneCnt);

      // Writes and Start while busy are dropped
      startPass(4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.WrEn = 1'b1;
         bus.WrAddr = 4'(i);
         bus.WrData = ~refMem[i];
         bus.MsgLen = 5'd16;
         bus.Start = 1'b1;
      end
      @(negedge clk);
      bus.WrEn = 1'b0;
      bus.Start = 1'b0;
      waitIdle("wrbusy", 1000);
      repeat (5) @(negedge clk);
      chk("wrbusy_stay_idle", {31'd0, bus.Busy}, 32'd0);
      checkPass("wrbusy", 4, 1);
      startPass(4);
      waitIdle("wrbusy2", 1000);
      checkPass("wrbusy2", 4, 1);

      // Transmitter held not-empty in SEND
      hold = 1;
      startPass(3);
      repeat (100) @(negedge clk);
      chk("hold_noxmit", capQ.size(), 0);
      chk("hold_state", {29'd0, bus.OutState}, 32'd2);
      hold = 0;
      waitIdle("hold", 1000);
      checkPass("hold", 3, 1);

      // Reset mid-pass after second symbol
      startPass(5);
      n = 0;
      while (capQ.size() < 2 && n < 500) begin
         @(negedge clk);
         n++;
      end
      #1 rst = 1'b0;
      #1 chk("midrst_outs", {bus.Busy, bus.OutState, bus.XMitGo, bus.Done, bus.TxData}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (60) @(negedge clk);
      chk("midrst_count", capQ.size(), 2);
      chk("midrst_idle", {31'd0, bus.Busy}, 32'd0);
      capQ.delete();
      xmitCycQ.delete();
      doneCycQ.delete();
      doneCnt = 0;
      startPass(5);
      waitIdle("postrst", 1000);
      checkPass("postrst", 5, 1);

      chk("no_consec_xmit", consecErr, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
